// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs loads/stores against external data memory over req/ack,
// stalls upstream while an access is in flight, and holds the MEM/WB pipeline register.
module mem_stage_ctrl #(
  parameter int len       = 32,
  parameter int ADDR_BASE = 1024,
  parameter int MAX_WAIT  = 255
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           wb_en_in,
  input  logic           mem_read_in,
  input  logic           mem_write_in,
  input  logic [len-1:0] alu_result_in,
  input  logic [len-1:0] src2_val_in,
  input  logic [4:0]     dest_in,
  output logic           mem_req,
  output logic           mem_we,
  output logic [len-1:0] mem_addr,
  output logic [len-1:0] mem_wdata,
  input  logic           mem_ack,
  input  logic [len-1:0] mem_rdata,
  output logic           freeze,
  output logic           wb_en_out,
  output logic           mem_read_out,
  output logic [4:0]     dest_out,
  output logic [len-1:0] alu_result_out,
  output logic [len-1:0] mem_data_out,
  output logic           timeout_err,
  output logic [1:0]     state_dbg
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   wait_cnt;
  logic            acc;
  logic            cnt_hit;
  logic [len-1:0]  addr_off;
  logic            lat_wb_en;
  logic            lat_mem_read;
  logic [4:0]      lat_dest;
  logic [len-1:0]  lat_alu;
  logic [len-1:0]  data_buf;

  // Handshake: mem_req rises with a stable address/we/wdata and holds them until the
  // cycle mem_ack is seen high at a clock edge; mem_rdata is taken on that same edge.
  assign acc       = mem_read_in | mem_write_in;
  assign cnt_hit   = (wait_cnt == CW'(MAX_WAIT - 1));
  assign addr_off  = alu_result_in - len'(ADDR_BASE);
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (acc) state_next = ACCESS;
      ACCESS:  if (mem_ack || cnt_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    freeze = 1'b0;
    case (state)
      IDLE:    freeze = acc;
      ACCESS:  freeze = 1'b1;
      default: freeze = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      wb_en_out      <= 1'b0;
      mem_read_out   <= 1'b0;
      dest_out       <= '0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
      timeout_err    <= 1'b0;
      wait_cnt       <= '0;
      lat_wb_en      <= 1'b0;
      lat_mem_read   <= 1'b0;
      lat_dest       <= '0;
      lat_alu        <= '0;
      data_buf       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            mem_req        <= 1'b1;
            mem_we         <= mem_write_in;
            mem_addr       <= {2'b00, addr_off[len-1:2]};
            mem_wdata      <= src2_val_in;
            lat_wb_en      <= wb_en_in;
            // A simultaneous read+write is performed as a write, so it never selects load data.
            lat_mem_read   <= mem_read_in & ~mem_write_in;
            lat_dest       <= dest_in;
            lat_alu        <= alu_result_in;
            wait_cnt       <= '0;
            wb_en_out      <= 1'b0;
            mem_read_out   <= 1'b0;
            dest_out       <= '0;
            alu_result_out <= '0;
            mem_data_out   <= '0;
          end else begin
            wb_en_out      <= wb_en_in;
            mem_read_out   <= mem_read_in;
            dest_out       <= dest_in;
            alu_result_out <= alu_result_in;
            mem_data_out   <= '0;
          end
        end
        ACCESS: begin
          wb_en_out      <= 1'b0;
          mem_read_out   <= 1'b0;
          dest_out       <= '0;
          alu_result_out <= '0;
          mem_data_out   <= '0;
          if (mem_ack) begin
            data_buf <= mem_we ? '0 : mem_rdata;
            mem_req  <= 1'b0;
            wait_cnt <= '0;
          end else if (cnt_hit) begin
            timeout_err <= 1'b1;
            data_buf    <= '0;
            mem_req     <= 1'b0;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          wb_en_out      <= lat_wb_en;
          mem_read_out   <= lat_mem_read;
          dest_out       <= lat_dest;
          alu_result_out <= lat_alu;
          mem_data_out   <= data_buf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: default instance plus a MAX_WAIT=4 instance for timeout.
module tb_mem_stage_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_en_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [31:0] alu_result_in = '0, src2_val_in = '0;
  logic [4:0]  dest_in = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        mem_req, mem_we, freeze, wb_en_out, mem_read_out, timeout_err;
  logic [31:0] mem_addr, mem_wdata, alu_result_out, mem_data_out;
  logic [4:0]  dest_out;
  logic [1:0]  state_dbg;

  logic        t_mem_req, t_mem_we, t_freeze, t_wb_en_out, t_mem_read_out, t_timeout_err;
  logic [31:0] t_mem_addr, t_mem_wdata, t_alu_result_out, t_mem_data_out;
  logic [4:0]  t_dest_out;
  logic [1:0]  t_state_dbg;

  int total = 0;
  int bad   = 0;
  int fcnt;

  always #5 clock = ~clock;

  mem_stage_ctrl dut (
    .clock(clock), .reset(reset), .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .alu_result_in(alu_result_in), .src2_val_in(src2_val_in),
    .dest_in(dest_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .freeze(freeze),
    .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .dest_out(dest_out),
    .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  mem_stage_ctrl #(.MAX_WAIT(4)) dut_to (
    .clock(clock), .reset(reset), .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .alu_result_in(alu_result_in), .src2_val_in(src2_val_in),
    .dest_in(dest_in), .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
    .mem_wdata(t_mem_wdata), .mem_ack(1'b0), .mem_rdata(mem_rdata), .freeze(t_freeze),
    .wb_en_out(t_wb_en_out), .mem_read_out(t_mem_read_out), .dest_out(t_dest_out),
    .alu_result_out(t_alu_result_out), .mem_data_out(t_mem_data_out),
    .timeout_err(t_timeout_err), .state_dbg(t_state_dbg)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] s2);
    wb_en_in = wb; mem_read_in = rd; mem_write_in = wr;
    dest_in = d; alu_result_in = alu; src2_val_in = s2;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    total++; if ({wb_en_out, mem_read_out, dest_out, alu_result_out, mem_data_out} !== '0) begin
      bad++; $display("FAIL reset_memwb got=%b/%b/%0d/%h/%h exp=0", wb_en_out, mem_read_out,
                      dest_out, alu_result_out, mem_data_out); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0 || state_dbg !== 2'd0 || mem_data_out !== 32'h0) begin
      bad++; $display("FAIL stray_ack got=%b/%0d/%h exp=0/0/0", mem_req, state_dbg, mem_data_out); end
  endtask

  task automatic test_reset_mid_access();
    drive(1, 1, 0, 6, 1028, 0);
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_req_up got=%b exp=1", mem_req); end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    total++; if (mem_req !== 1'b0 || state_dbg !== 2'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%0d exp=0/0", mem_req, state_dbg); end
    total++; if ({wb_en_out, mem_read_out, dest_out, alu_result_out, mem_data_out} !== '0) begin
      bad++; $display("FAIL mid_reset_memwb got=%b/%0d/%h exp=0", wb_en_out, dest_out, mem_data_out); end
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0 || state_dbg !== 2'd0 || mem_data_out !== 32'h0 || freeze !== 1'b0) begin
      bad++; $display("FAIL mid_late_ack got=%b/%0d/%h/%b exp=0/0/0/0", mem_req, state_dbg,
                      mem_data_out, freeze); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  dv [3];
    logic [31:0] av [3];
    dv[0] = 3; dv[1] = 4; dv[2] = 5;
    av[0] = 7; av[1] = 8; av[2] = 9;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, dv[i], av[i], 0);
      total++; if (freeze !== 1'b0) begin bad++; $display("FAIL b2b_freeze%0d got=%b exp=0", i, freeze); end
      tick();
      total++; if (wb_en_out !== 1'b1 || dest_out !== dv[i] || alu_result_out !== av[i]) begin
        bad++; $display("FAIL b2b_memwb%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, wb_en_out, dest_out,
                        alu_result_out, dv[i], av[i]); end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_load();
    fcnt = 0;
    drive(1, 1, 0, 6, 1028, 0);
    if (freeze) fcnt++;
    tick();
    if (freeze) fcnt++;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd1) begin
      bad++; $display("FAIL load_req got=%b/%b/%0d exp=1/0/1", mem_req, mem_we, mem_addr); end
    total++; if (wb_en_out !== 1'b0) begin bad++; $display("FAIL load_bubble got=%b exp=0", wb_en_out); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    if (freeze) fcnt++;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%b exp=0", mem_req); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (fcnt !== 2) begin bad++; $display("FAIL load_freeze_cycles got=%0d exp=2", fcnt); end
    total++; if (wb_en_out !== 1'b1 || mem_read_out !== 1'b1 || dest_out !== 5'd6 ||
                 mem_data_out !== 32'hDEAD_BEEF || alu_result_out !== 32'd1028) begin
      bad++; $display("FAIL load_memwb got=%b/%b/%0d/%h/%0d exp=1/1/6/deadbeef/1028", wb_en_out,
                      mem_read_out, dest_out, mem_data_out, alu_result_out); end
  endtask

  task automatic test_store_wait();
    fcnt = 0;
    drive(0, 0, 1, 2, 1040, 32'h55);
    if (freeze) fcnt++;
    tick();
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd4 || mem_wdata !== 32'h55) begin
      bad++; $display("FAIL store_req got=%b/%b/%0d/%h exp=1/1/4/55", mem_req, mem_we, mem_addr, mem_wdata); end
    for (int i = 0; i < 5; i++) begin
      if (freeze) fcnt++;
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'd4) begin
        bad++; $display("FAIL store_hold%0d got=%b/%0d exp=1/4", i, mem_req, mem_addr); end
      mem_ack = (i == 4); mem_rdata = 32'h9999_9999;
      tick();
    end
    mem_ack = 1'b0;
    if (freeze) fcnt++;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (fcnt !== 6) begin bad++; $display("FAIL store_freeze_cycles got=%0d exp=6", fcnt); end
    total++; if (wb_en_out !== 1'b0 || mem_data_out !== 32'h0 || mem_read_out !== 1'b0) begin
      bad++; $display("FAIL store_memwb got=%b/%h/%b exp=0/0/0", wb_en_out, mem_data_out, mem_read_out); end
  endtask

  task automatic test_read_write_both();
    drive(1, 1, 1, 9, 1024, 32'hABCD);
    tick();
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'd0 || mem_wdata !== 32'hABCD) begin
      bad++; $display("FAIL both_req got=%b/%0d/%h exp=1/0/abcd", mem_we, mem_addr, mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    tick();
    mem_ack = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (mem_read_out !== 1'b0 || mem_data_out !== 32'h0 || wb_en_out !== 1'b1 || dest_out !== 5'd9) begin
      bad++; $display("FAIL both_memwb got=%b/%h/%b/%0d exp=0/0/1/9", mem_read_out, mem_data_out,
                      wb_en_out, dest_out); end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1, 1, 0, 7, 1032, 0);
    total++; if (t_freeze !== 1'b1) begin bad++; $display("FAIL to_freeze_idle got=%b exp=1", t_freeze); end
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (t_mem_req !== 1'b1 || t_freeze !== 1'b1 || t_timeout_err !== 1'b0) begin
        bad++; $display("FAIL to_wait%0d got=%b/%b/%b exp=1/1/0", i, t_mem_req, t_freeze, t_timeout_err); end
      tick();
    end
    total++; if (t_mem_req !== 1'b0 || t_timeout_err !== 1'b1 || t_freeze !== 1'b0) begin
      bad++; $display("FAIL to_abort got=%b/%b/%b exp=0/1/0", t_mem_req, t_timeout_err, t_freeze); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (t_wb_en_out !== 1'b1 || t_dest_out !== 5'd7 || t_mem_data_out !== 32'h0) begin
      bad++; $display("FAIL to_memwb got=%b/%0d/%h exp=1/7/0", t_wb_en_out, t_dest_out, t_mem_data_out); end
    drive(1, 0, 0, 2, 5, 0);
    total++; if (t_freeze !== 1'b0) begin bad++; $display("FAIL to_resume_freeze got=%b exp=0", t_freeze); end
    tick();
    total++; if (t_dest_out !== 5'd2 || t_alu_result_out !== 32'd5 || t_timeout_err !== 1'b1) begin
      bad++; $display("FAIL to_resume got=%0d/%0d/%b exp=2/5/1", t_dest_out, t_alu_result_out, t_timeout_err); end
    do_reset();
    total++; if (t_timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", t_timeout_err); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_access();
    test_back_to_back();
    test_load();
    test_store_wait();
    test_read_write_both();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the EXE/MEM pipeline register: takes the registered EXE/MEM outputs, runs loads and stores against an external data memory over a req/ack handshake, and stalls the front of the pipeline until the access completes.
- Contains the MEM/WB pipeline register. Non-memory instructions pass through with one cycle of latency.

Parameters:
- len, 32, datapath width (address, data, ALU result)
- ADDR_BASE, 1024, byte-address base of data memory; subtracted before word indexing
- MAX_WAIT, 255, maximum ACCESS cycles without ack before a timeout abort (must be ≥1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low
- wb_en_in  in  1  write-back enable from EXE/MEM
- mem_read_in  in  1  load request from EXE/MEM
- mem_write_in  in  1  store request from EXE/MEM
- alu_result_in  in  len  effective byte address or ALU result
- src2_val_in  in  len  store data
- dest_in  in  5  destination register
- mem_req  out  1  memory request (registered)
- mem_we  out  1  1 = write, 0 = read (registered)
- mem_addr  out  len  word address (registered)
- mem_wdata  out  len  store data (registered)
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle
- mem_rdata  in  len  load data
- freeze  out  1  stall request to upstream stages/EXE/MEM (combinational from state + inputs)
- wb_en_out  out  1  MEM/WB write-back enable
- mem_read_out  out  1  MEM/WB select-load-data flag
- dest_out  out  5  MEM/WB destination
- alu_result_out  out  len  MEM/WB ALU result
- mem_data_out  out  len  MEM/WB load data
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; all registered outputs = 0, including mem_req, mem_we, mem_addr, mem_wdata, all MEM/WB outputs and timeout_err; wait counter = 0. Reset takes priority over everything, including mid-ACCESS. A mem_ack arriving after reset is ignored.
- The access condition is acc = mem_read_in | mem_write_in. If both are set, the block performs a write and mem_read_out = 0.
- FSM has three states: IDLE, ACCESS, DONE.
  - IDLE, acc=0:
    - freeze=0.
    - MEM/WB register loads the inputs; mem_data_out=0.
  - IDLE, acc=1:
    - freeze=1; MEM/WB loads a bubble (all fields 0).
    - At the edge: mem_req=1, mem_we=mem_write_in, mem_addr=(alu_result_in−ADDR_BASE)>>2 (modulo 2^len, low 2 bits dropped), mem_wdata=src2_val_in; wb_en, mem_read, dest and alu_result are latched internally; next state = ACCESS.
  - ACCESS:
    - freeze=1; MEM/WB loads a bubble; mem_req and mem_addr/we/wdata are held stable.
    - mem_ack=1 at an edge: capture mem_rdata into the data buffer (0 for writes), mem_req←0, counter←0, next state = DONE.
    - No ack: counter increments. When counter reaches MAX_WAIT−1 without ack, at that edge: timeout_err←1, mem_req←0, buffer←0, next state = DONE.
  - DONE:
    - freeze=0.
    - At the edge: MEM/WB loads the latched fields plus the buffer; next state = IDLE.
    - Upstream advances on this same edge; the new EXE/MEM contents are evaluated in IDLE on the following cycle.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction with ack in the first ACCESS cycle: 2 freeze cycles; result appears in MEM/WB 3 edges after the instruction enters.
  - Each extra ack-wait cycle adds 1 freeze cycle.
- mem_ack is ignored outside ACCESS.
- timeout_err is cleared only by reset.
- EXE/MEM inputs are required to remain stable while freeze=1.

Test Plan:
- Reset mid-ACCESS (mem_req=1, reset=0 for one edge) -> next cycle mem_req=0, all MEM/WB outputs 0, state IDLE. A later mem_ack=1 has no effect.
- Three back-to-back ALU ops (wb_en=1, dest=3/4/5, alu_result=7/8/9) -> freeze stays 0; MEM/WB shows (3,7), (4,8), (5,9) on consecutive cycles with a 1-cycle lag.
- Load, alu_result=1028, dest=6, mem_ack on the first ACCESS cycle, mem_rdata=0xDEADBEEF:
  - mem_addr=1; freeze high for exactly 2 cycles.
  - Then wb_en_out=1, mem_read_out=1, dest_out=6, mem_data_out=0xDEADBEEF.
- Store, alu_result=1040, src2_val=0x55, ack after 4 wait cycles -> mem_we=1, mem_addr=4, mem_wdata=0x55; freeze high 6 cycles; wb_en_out=0, mem_data_out=0.
- MAX_WAIT=4, load, no ack -> mem_req drops after 4 ACCESS cycles; timeout_err=1 and stays 1; mem_data_out=0; the pipeline resumes.
- mem_read_in=mem_write_in=1, alu_result=1024 -> a write is issued to mem_addr=0; mem_read_out=0 in MEM/WB.
